load_data_reader: RTL

//  Read side of the data-memory byte-lane interface: accepts a load (lb/lbu/lh/lhu/lw) from the
//  M stage and issues a word-aligned read to the data memory / bridge. It waits for the read data,

---
 rtl/load_pkg.sv | 23 ++
 rtl/load_extend.sv | 26 ++
 rtl/load_data_reader.sv | 131 +++++++++++++
 3 files changed

// File: rtl/load_pkg.sv
// Shared encodings for the load data reader: load type codes, FSM states, data width.
package load_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  // Undefined codes behave as lw, so they also require word alignment.
  function automatic logic ld_misaligned(logic [2:0] ld_type, logic [1:0] a);
    case (ld_type)
      LD_LB, LD_LBU: return 1'b0;
      LD_LH, LD_LHU: return a[0];
      default:       return a != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Lane select and sign/zero extension of a read word for lb/lbu/lh/lhu/lw.
module load_extend
  import load_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [2:0]        ld_type,
  input  logic [1:0]        addr_lo,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    case (ld_type)
      LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  data = {24'h0, byte_sel};
      LD_LH:   data = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  data = {16'h0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_data_reader.sv
// Load path to data memory: word-aligned read, bounded wait, lane extension, valid/ready result.
// Optional misaligned-address trap enabled by defining LOAD_ALIGN_CHECK_EN.
module load_data_reader
  import load_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [2:0]        req_type,
  input  logic [4:0]        req_rd,
  output logic              mem_rd_en,
  output logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [4:0]        rsp_rd,
  output logic              rsp_err,
  output logic              stall
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [29:0]       waddr_q, waddr_d;
  logic [1:0]        alo_q, alo_d;
  logic [2:0]        type_q, type_d;
  logic [4:0]        rd_q, rd_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] ext_data;

  load_extend u_extend (
    .word    (mem_rdata),
    .ld_type (type_q),
    .addr_lo (alo_q),
    .data    (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      waddr_q <= '0;
      alo_q   <= '0;
      type_q  <= LD_LW;
      rd_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      alo_q   <= alo_d;
      type_q  <= type_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    alo_d   = alo_q;
    type_d  = type_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          waddr_d = req_addr[31:2];
          alo_d   = req_addr[1:0];
          type_d  = req_type;
          rd_d    = req_rd;
`ifdef LOAD_ALIGN_CHECK_EN
          if (ld_misaligned(req_type, req_addr[1:0])) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            data_d  = '0;
          end else begin
            state_d = S_ISSUE;
          end
`else
          state_d = S_ISSUE;
`endif
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Data arriving in the timeout cycle still counts as a good read.
        if (mem_rvalid) begin
          data_d  = ext_data;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == TimeoutLast) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign mem_rd_en = (state_q == S_ISSUE);
  assign mem_addr  = {waddr_q, 2'b00};
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = data_q;
  assign rsp_rd    = rd_q;
  assign rsp_err   = err_q;
  assign stall     = (state_q != S_IDLE);

endmodule
